// File: rtl/bmem_pkg.sv
// Shared types and constants for the 64-bit burst-memory (bmem) interface.
package bmem_pkg;

    localparam int BMEM_BEAT_W     = 64;
    localparam int BMEM_BURST_LEN  = 4;
    localparam int BMEM_LINE_BYTES = 32;
    localparam int BMEM_BEAT_IDX_W = $clog2(BMEM_BURST_LEN);
    localparam int BMEM_LINE_OFS_W = $clog2(BMEM_LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } bmem_state_t;

    typedef logic [BMEM_BEAT_IDX_W-1:0] bmem_beat_t;

endpackage

// File: rtl/bmem_line_ram.sv
// Line storage: DEPTH_LINES x 4 beats x 64 b, beat-granular write port and a
// registered read port whose output holds when no read is issued.
module bmem_line_ram
    import bmem_pkg::*;
#(
    parameter int DEPTH_LINES = 256,
    localparam int IDX_W = $clog2(DEPTH_LINES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       w_idx_i,
    input  bmem_beat_t             w_beat_i,
    input  logic [BMEM_BEAT_W-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [IDX_W-1:0]       r_idx_i,
    input  bmem_beat_t             r_beat_i,
    output logic [BMEM_BEAT_W-1:0] rdata_o
);

    logic [BMEM_BEAT_W-1:0] mem_q [DEPTH_LINES*BMEM_BURST_LEN];
    logic [BMEM_BEAT_W-1:0] rdata_q;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[{w_idx_i, w_beat_i}] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {BMEM_BEAT_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[{r_idx_i, r_beat_i}];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bmem_responder.sv
// Memory end of the bmem burst protocol: accepts one line request at a time,
// absorbs 4-beat write bursts and returns 4-beat reads after a fixed latency.
module bmem_responder
    import bmem_pkg::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int RD_LATENCY  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            bmem_addr,
    input  logic                   bmem_read,
    input  logic                   bmem_write,
    input  logic [BMEM_BEAT_W-1:0] bmem_wdata,
    output logic                   bmem_ready,
    output logic [31:0]            bmem_raddr,
    output logic [BMEM_BEAT_W-1:0] bmem_rdata,
    output logic                   bmem_rvalid,
    output logic                   proto_err
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bmem_beat_t       BEAT_ZERO = {BMEM_BEAT_IDX_W{1'b0}};
    localparam bmem_beat_t       BEAT_ONE  = BMEM_BEAT_IDX_W'(1);
    localparam bmem_beat_t       BEAT_LAST = BMEM_BEAT_IDX_W'(BMEM_BURST_LEN - 1);

    bmem_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    bmem_beat_t       beat_q, beat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      raddr_q, raddr_d;
    logic             perr_q, perr_d;
    logic             ready_q;
    logic             rvalid_q;

    logic [IDX_W-1:0] addr_idx_s;
    logic [IDX_W-1:0] idx_sel_s;
    logic             wr_en_s;
    bmem_beat_t       wr_beat_s;
    logic             rd_en_s;
    logic             unused_addr_s;

    // Upper address bits beyond the index alias onto the same line.
    assign addr_idx_s    = bmem_addr[BMEM_LINE_OFS_W +: IDX_W];
    assign unused_addr_s = ^bmem_addr[BMEM_LINE_OFS_W-1:0];
    // In IDLE the request address is used directly so beat 0 / a 1-cycle read need no latched index.
    assign idx_sel_s     = (state_q == IDLE) ? addr_idx_s : idx_q;

    // Next-state, burst bookkeeping and protocol-error detection.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        perr_d    = perr_q;
        wr_en_s   = 1'b0;
        wr_beat_s = beat_q;
        case (state_q)
            IDLE: begin
                if (bmem_write) begin
                    wr_en_s   = 1'b1;
                    wr_beat_s = BEAT_ZERO;
                    idx_d     = addr_idx_s;
                    beat_d    = BEAT_ONE;
                    state_d   = WR_BURST;
                    perr_d    = perr_q | bmem_read;
                end else if (bmem_read) begin
                    idx_d   = addr_idx_s;
                    raddr_d = {bmem_addr[31:BMEM_LINE_OFS_W], {BMEM_LINE_OFS_W{1'b0}}};
                    cnt_d   = CNT_LOAD;
                    beat_d  = BEAT_ZERO;
                    state_d = (RD_LATENCY == 1) ? RD_BURST : RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                perr_d = perr_q | bmem_read;
                if (bmem_write) begin
                    wr_en_s = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = BEAT_ZERO;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    state_d = WR_BURST;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RD_BURST;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_BURST: begin
                if (beat_q == BEAT_LAST) begin
                    beat_d  = BEAT_ZERO;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read one beat ahead so the registered RAM output lines up with rvalid.
    assign rd_en_s = (state_d == RD_BURST);

    // State and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= {IDX_W{1'b0}};
            beat_q   <= BEAT_ZERO;
            cnt_q    <= {CNT_W{1'b0}};
            raddr_q  <= 32'h0000_0000;
            perr_q   <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            perr_q   <= perr_d;
            ready_q  <= (state_d == IDLE);
            rvalid_q <= rd_en_s;
        end
    end

    bmem_line_ram #(
        .DEPTH_LINES(DEPTH_LINES)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_en_s & ~rst),
        .w_idx_i  (idx_sel_s),
        .w_beat_i (wr_beat_s),
        .wdata_i  (bmem_wdata),
        .re_i     (rd_en_s & ~rst),
        .r_idx_i  (idx_sel_s),
        .r_beat_i (beat_d),
        .rdata_o  (bmem_rdata)
    );

    assign bmem_ready  = ready_q;
    assign bmem_raddr  = raddr_q;
    assign bmem_rvalid = rvalid_q;
    assign proto_err   = perr_q;

endmodule

// File: doc/bmem_responder.md
Name: bmem_responder

Overview:
- Synthesizable responder for the 64-bit burst-memory (bmem) interface driven by the cache/top level; it is the memory end of that protocol.
- Serves one line (4 beats x 64 b = 32 B) per request from an internal line array, with a programmable fixed read latency.
- Used as the on-chip backing memory in FPGA/emulation builds and as the reference responder for cache benches.

Parameters:
- DEPTH_LINES, 256, number of 32-byte lines stored (power of 2).
- RD_LATENCY, 8, cycles from read accept to first rvalid beat (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- bmem_addr  input  32  request line address; bits [4:0] ignored
- bmem_read  input  1  read request
- bmem_write  input  1  write request/beat valid
- bmem_wdata  input  64  write beat data
- bmem_ready  output  1  responder can accept a new request this cycle
- bmem_raddr  output  32  line address of the returning read, {addr[31:5],5'b0}
- bmem_rdata  output  64  read beat data
- bmem_rvalid  output  1  read beat valid
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: bmem_ready=1, bmem_rvalid=0, bmem_rdata=0, bmem_raddr=0, proto_err=0, state=IDLE.
- Array contents are not reset; they persist across rst.
- Index = bmem_addr[4+log2(DEPTH_LINES):5]; higher address bits alias (modulo wrap).
- Beat b (0..3) is the 64-bit word at byte offset 8*b within the line.
- FSM states: IDLE, WR_BURST, RD_WAIT, RD_BURST.
- IDLE, bmem_ready=1:
  - bmem_write=1: accept. Write beat 0 this cycle, latch the index, go to WR_BURST with beat count 1.
  - Else bmem_read=1: accept. Latch index and raddr, load latency counter = RD_LATENCY-1, go to RD_WAIT (or straight to RD_BURST if RD_LATENCY=1).
  - read and write both high: write wins, read is dropped, proto_err sets.
- WR_BURST, bmem_ready=0:
  - Each cycle with bmem_write=1 writes the next beat.
  - A cycle with bmem_write=0 stalls without advancing.
  - After beat 3 is written, go to IDLE (ready=1 the following cycle).
  - bmem_read=1 here sets proto_err and is ignored.
- RD_WAIT, bmem_ready=0: decrement the counter; at 0, go to RD_BURST.
- RD_BURST, bmem_ready=0:
  - rvalid=1 for exactly 4 consecutive cycles, beats 0,1,2,3 in order; raddr held constant.
  - No backpressure exists on the read path.
  - After beat 3, go to IDLE.
- Read timing: accepted at cycle T gives beats at T+RD_LATENCY .. T+RD_LATENCY+3, and ready=1 at T+RD_LATENCY+4.
- Write-then-read of the same line: the read returns the newly written data, because the write fully completes before the read can be accepted.
- Requests arriving while bmem_ready=0 are ignored, except for the proto_err cases above.
- bmem_rdata is registered and holds its last value when rvalid=0.
- Reset mid-operation: next cycle state=IDLE, rvalid=0, ready=1. Beats already written remain; remaining beats are not written.
- proto_err clears only on rst.

Decomposition:
- Shared package bmem_pkg:
  - BMEM_BEAT_W=64, BMEM_BURST_LEN=4, BMEM_LINE_BYTES=32.
  - bmem_state_t enum {IDLE, WR_BURST, RD_WAIT, RD_BURST}.
- Sub-module bmem_line_ram: DEPTH_LINES x 4 x 64 array, one beat-granular write port and one registered read port (index, beat select). The FSM, counters and handshake stay in bmem_responder.

Test Plan:
- Reset, then idle 5 cycles -> ready=1, rvalid=0, proto_err=0 throughout.
- Write burst to addr 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 (4 consecutive cycles) -> ready=0 for cycles 2-4, ready=1 on cycle 5. Then read 0x0000_0047 at cycle T -> rvalid at T+8..T+11, beats in the same order, raddr=0x0000_0040.
- Write burst with bmem_write dropped for 2 cycles after beat 1 -> no beat skipped; readback shows all 4 beats correct.
- DEPTH_LINES=256: write line 0x0000_0000, read 0x0000_2000 -> aliased data returned.
- Read and write both high in IDLE -> write performed, no rvalid follows, proto_err=1 until rst.
- rst asserted at RD_WAIT counter=3 -> next cycle ready=1, rvalid=0, and no beats ever appear. A new read of the same line then returns correct data with full RD_LATENCY.
